// File: rtl/execute_multicycle_ctrl.sv
// Issue/complete controller shared by the multi-cycle execute units: start pulse,
// wait for ready, capture and hold the result, drain cleared ops, watchdog abort.
module execute_multicycle_ctrl #(
  parameter  int NUM_UNITS = 4,
  parameter  int XLEN      = 32,
  parameter  int TIMEOUT   = 64,
  localparam int UW        = $clog2(NUM_UNITS),
  localparam int CW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      issue_valid,
  input  logic [UW-1:0]             issue_unit,
  input  logic                      clear,
  input  logic                      hold,
  input  logic [NUM_UNITS-1:0]      unit_ready,
  input  logic [NUM_UNITS*XLEN-1:0] unit_result,
  output logic [NUM_UNITS-1:0]      unit_enable,
  output logic                      stall,
  output logic                      result_valid,
  output logic [XLEN-1:0]           result,
  output logic                      timeout
);

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN, DONE} state_t;

  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  state_t          state;
  logic [UW-1:0]   cur;
  logic [CW-1:0]   cnt;
  logic            unit_ok;
  logic            acc;
  logic            cur_ready;
  logic [XLEN-1:0] cur_result;
  logic            wd_hit;
  logic            abort;
  logic            stall_c;

  assign unit_ok    = {1'b0, issue_unit} < (UW + 1)'(NUM_UNITS);
  assign acc        = issue_valid & ~clear & unit_ok &
                      ((state == IDLE) | ((state == DONE) & ~hold));
  assign cur_ready  = unit_ready[cur];
  assign cur_result = unit_result[cur * XLEN +: XLEN];

  // cnt keeps counting across a clear into DRAIN, so it can sit one past the
  // limit; >= makes that case still terminate.
  assign wd_hit = (TIMEOUT > 0) && (cnt >= CNT_LAST);
  assign abort  = ~cur_ready & wd_hit &
                  (((state == BUSY) & ~clear) | (state == DRAIN));

  always_comb begin
    stall_c = 1'b0;
    case (state)
      IDLE:    stall_c = acc;
      BUSY:    stall_c = ~clear & ~cur_ready;
      DRAIN:   stall_c = issue_valid;
      DONE:    stall_c = issue_valid & hold;
      default: stall_c = 1'b0;
    endcase
  end

  // Combinational outputs are masked by reset so everything reads 0 while it is held.
  assign unit_enable  = (reset & acc) ? (NUM_UNITS'(1) << issue_unit) : '0;
  assign stall        = reset & stall_c;
  assign timeout      = reset & abort;
  assign result_valid = (state == DONE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cur    <= '0;
      cnt    <= '0;
      result <= '0;
    end else begin
      if (acc) begin
        cur <= issue_unit;
        cnt <= '0;
      end
      case (state)
        IDLE: begin
          if (acc) state <= BUSY;
        end
        BUSY: begin
          if (clear) begin
            state <= DRAIN;
            cnt   <= cnt + 1'b1;
          end else if (cur_ready) begin
            result <= cur_result;
            state  <= DONE;
          end else if (abort) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (cur_ready || abort) state <= IDLE;
          else                    cnt   <= cnt + 1'b1;
        end
        DONE: begin
          if (clear)      state <= IDLE;
          else if (!hold) state <= acc ? BUSY : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_execute_multicycle_ctrl.sv
// Bench for execute_multicycle_ctrl: directed scenarios then random traffic, all
// checked every cycle against an op-tracking reference model.
module tb_execute_multicycle_ctrl;
  localparam int NU = 5;
  localparam int XL = 32;
  localparam int TO = 8;
  localparam int UW = 3;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             issue_valid = 1'b0;
  logic [UW-1:0]    issue_unit = '0;
  logic             clear = 1'b0;
  logic             hold = 1'b0;
  logic [NU-1:0]    unit_ready = '0;
  logic [NU*XL-1:0] unit_result = '0;
  logic [NU-1:0]    unit_enable;
  logic             stall;
  logic             result_valid;
  logic [XL-1:0]    result;
  logic             timeout;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model: op in flight (-1 none), whether it is being drained,
  // whether a finished result is being held, and the cycle it was issued
  int            inflight = -1;
  bit            draining = 0;
  bit            have_result = 0;
  logic [XL-1:0] m_result = '0;
  int            cyc = 0;
  int            issue_cyc = 0;

  always #5 clock = ~clock;

  execute_multicycle_ctrl #(.NUM_UNITS(NU), .XLEN(XL), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .issue_valid(issue_valid), .issue_unit(issue_unit),
    .clear(clear), .hold(hold), .unit_ready(unit_ready), .unit_result(unit_result),
    .unit_enable(unit_enable), .stall(stall), .result_valid(result_valid),
    .result(result), .timeout(timeout)
  );

  task automatic chk(input string tag, input logic [XL-1:0] obs, input logic [XL-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    inflight = -1; draining = 0; have_result = 0; m_result = '0;
  endtask

  // Called just after a negedge with inputs already driven: checks all outputs,
  // steps through the rising edge, advances the model, returns at the next negedge.
  task automatic cycle(input string tag);
    bit busy, rdy, to_hit, acc;
    logic [NU-1:0] e_en;
    logic e_stall;
    #2;
    busy   = (inflight >= 0) && !draining;
    rdy    = (inflight >= 0) && unit_ready[inflight];
    to_hit = (inflight >= 0) && !rdy && !(busy && clear) && (cyc - issue_cyc - 1 >= TO - 1);
    acc    = issue_valid && !clear && (int'(issue_unit) < NU) &&
             (inflight < 0) && (!have_result || !hold);
    e_en   = acc ? (NU'(1) << issue_unit) : '0;
    if (have_result)   e_stall = issue_valid && hold;
    else if (draining) e_stall = issue_valid;
    else if (busy)     e_stall = !clear && !rdy;
    else               e_stall = acc;
    chk({tag, ".enable"}, XL'(unit_enable), XL'(e_en));
    chk({tag, ".stall"}, XL'(stall), XL'(e_stall));
    chk({tag, ".result_valid"}, XL'(result_valid), XL'(have_result));
    chk({tag, ".result"}, result, m_result);
    chk({tag, ".timeout"}, XL'(timeout), XL'(to_hit));
    @(posedge clock);
    cyc++;
    if (busy) begin
      if (clear) draining = 1;
      else if (rdy) begin
        m_result = unit_result[inflight*XL +: XL];
        have_result = 1;
        inflight = -1;
      end else if (to_hit) inflight = -1;
    end else if (draining) begin
      if (rdy || to_hit) begin draining = 0; inflight = -1; end
    end else if (have_result && (clear || !hold)) have_result = 0;
    if (acc) begin inflight = int'(issue_unit); issue_cyc = cyc - 1; draining = 0; end
    @(negedge clock);
  endtask

  initial begin
    // reset state, with an issue pending to show enable/stall are masked
    issue_valid = 1'b1; issue_unit = 3'd2;
    #2;
    chk("rst.enable", XL'(unit_enable), '0);
    chk("rst.stall", XL'(stall), '0);
    chk("rst.result_valid", XL'(result_valid), '0);
    chk("rst.result", result, '0);
    chk("rst.timeout", XL'(timeout), '0);
    @(negedge clock);
    reset = 1'b1; issue_valid = 1'b0;
    cycle("idle");

    // single op on unit 2, ready on the third BUSY cycle
    issue_valid = 1'b1; issue_unit = 3'd2;
    #1 chk("t1.enable", XL'(unit_enable), 32'h4);
    cycle("t1.issue");
    issue_valid = 1'b0;
    cycle("t1.b1");
    cycle("t1.b2");
    unit_ready = 5'b00100; unit_result[2*XL +: XL] = 32'hDEADBEEF;
    #1 chk("t1.stall_done", XL'(stall), '0);
    cycle("t1.b3");
    unit_ready = '0;
    #1 chk("t1.valid", XL'(result_valid), 32'h1);
    chk("t1.result", result, 32'hDEADBEEF);
    cycle("t1.done");

    // result held stable for 4 cycles; an issue inside the window must stall
    issue_valid = 1'b1; issue_unit = 3'd1;
    cycle("t2.issue");
    issue_valid = 1'b0;
    unit_ready = 5'b00010; unit_result[1*XL +: XL] = 32'h12345678;
    cycle("t2.b1");
    unit_ready = '0; hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue_valid = (i == 1); issue_unit = 3'd3;
      #1 chk("t2.hold_result", result, 32'h12345678);
      chk("t2.hold_valid", XL'(result_valid), 32'h1);
      cycle("t2.hold");
    end
    // back-to-back issue from DONE
    hold = 1'b0; issue_valid = 1'b1; issue_unit = 3'd1;
    #1 chk("t3.enable", XL'(unit_enable), 32'h2);
    chk("t3.valid", XL'(result_valid), 32'h1);
    cycle("t3.issue");
    issue_valid = 1'b0; unit_ready = 5'b00010; unit_result[1*XL +: XL] = 32'h0BADF00D;
    cycle("t3.b1");
    unit_ready = '0;
    cycle("t3.done");

    // clear one cycle after enable, unit 0 answers 5 cycles later
    issue_valid = 1'b1; issue_unit = 3'd0;
    cycle("t4.issue");
    issue_valid = 1'b0; clear = 1'b1;
    #1 chk("t4.clear_stall", XL'(stall), '0);
    cycle("t4.clear");
    clear = 1'b0; issue_valid = 1'b1; issue_unit = 3'd2;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin unit_ready = 5'b00001; unit_result[0 +: XL] = 32'hAA; end
      #1 chk("t4.drain_stall", XL'(stall), 32'h1);
      chk("t4.drain_enable", XL'(unit_enable), '0);
      cycle("t4.drain");
    end
    unit_ready = '0; issue_valid = 1'b0;
    #1 chk("t4.valid", XL'(result_valid), '0);
    chk("t4.result_kept", result, 32'h0BADF00D);
    cycle("t4.idle");

    // watchdog: unit 3 never answers
    issue_valid = 1'b1; issue_unit = 3'd3;
    cycle("t5.issue");
    issue_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      #1 chk("t5.timeout", XL'(timeout), XL'(i == 8));
      cycle("t5.busy");
    end
    issue_valid = 1'b1; issue_unit = 3'd4;
    #1 chk("t5.reissue", XL'(unit_enable), 32'h10);
    cycle("t5.reissue");
    issue_valid = 1'b0; unit_ready = 5'b10000; unit_result[4*XL +: XL] = 32'h55;
    cycle("t5.b1");
    unit_ready = '0;
    cycle("t5.done");

    // out-of-range unit is ignored
    issue_valid = 1'b1; issue_unit = 3'd5;
    #1 chk("t6.enable", XL'(unit_enable), '0);
    chk("t6.stall", XL'(stall), '0);
    cycle("t6.bad");
    // reset mid-BUSY clears everything at once
    issue_unit = 3'd1;
    cycle("t6.issue");
    #1 reset = 1'b0;
    #1 chk("t6.rst_enable", XL'(unit_enable), '0);
    chk("t6.rst_stall", XL'(stall), '0);
    chk("t6.rst_valid", XL'(result_valid), '0);
    chk("t6.rst_result", result, '0);
    chk("t6.rst_timeout", XL'(timeout), '0);
    @(negedge clock);
    reset = 1'b1; issue_valid = 1'b0;
    model_reset();
    cycle("t6.idle");

    // random traffic
    for (int i = 0; i < 600; i++) begin
      issue_valid = 1'($urandom_range(0, 1));
      issue_unit  = 3'($urandom_range(0, 7));
      clear       = ($urandom_range(0, 11) == 0);
      hold        = ($urandom_range(0, 2) == 0);
      unit_ready  = NU'($urandom & $urandom);
      for (int u = 0; u < NU; u++) unit_result[u*XL +: XL] = $urandom;
      cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
